mel_frame_sched: RTL and testbench

- Frame scheduler/sequencer for the mel-spectrogram pipeline (STFT -> PP buffer -> mel filterbank).
- On a run command it performs these steps in order:
  - loads WIN_LEN window coefficients;
  - primes the pipeline with WIN_LEN samples;
  - issues HOP_LEN-sample hops, one per frame;
  - gates the input stream until MEL_BANDS mel outputs return for the current frame.
- Mel outputs are tagged with frame/band indices. Runs stop after N_FRAMES frames, on abort or on watchdog timeout.

---
 rtl/mel_frame_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_mel_frame_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_frame_sched.sv
// Frame scheduler for the STFT -> PP buffer -> mel filterbank pipeline: loads the window,
// primes and hops the sample stream, then stalls it until each frame's mel bands return.
module mel_frame_sched #(
    parameter int WIDTH     = 16,
    parameter int N_FRAMES  = 101,
    parameter int WIN_LEN   = 480,
    parameter int HOP_LEN   = 160,
    parameter int MEL_BANDS = 40,
    parameter int TIMEOUT   = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          run_i,
    input  logic                          abort_i,
    input  logic                          coe_vld_i,
    input  logic [WIDTH-1:0]              coe_data_i,
    output logic                          coe_rdy_o,
    input  logic                          s_vld_i,
    input  logic [WIDTH-1:0]              s_re_i,
    input  logic [WIDTH-1:0]              s_im_i,
    output logic                          s_rdy_o,
    output logic                          win_coe_lut_en_o,
    output logic [WIDTH-1:0]              win_coe_o,
    output logic                          start_o,
    output logic [WIDTH-1:0]              signal_re_o,
    output logic [WIDTH-1:0]              signal_im_o,
    input  logic                          mel_avail_i,
    input  logic [WIDTH-1:0]              mel_data_i,
    output logic                          m_vld_o,
    output logic [WIDTH-1:0]              m_data_o,
    output logic [$clog2(N_FRAMES)-1:0]   m_frame_o,
    output logic [$clog2(MEL_BANDS)-1:0]  m_band_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_timeout_o,
    output logic                          err_stray_o
);

    localparam int FW = $clog2(N_FRAMES);
    localparam int BW = $clog2(MEL_BANDS);
    localparam int CW = $clog2(WIN_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] WIN_LAST   = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] HOP_LAST   = CW'(HOP_LEN - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(N_FRAMES - 1);
    localparam logic [BW-1:0] BAND_LAST  = BW'(MEL_BANDS - 1);
    localparam logic [TW-1:0] WDOG_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_HOP,
        S_WAIT_MEL,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [FW-1:0]     frame_q;
    logic [BW-1:0]     band_q;
    logic [TW-1:0]     wdog_q;

    logic              win_en_q;
    logic [WIDTH-1:0]  win_coe_q;
    logic              start_q;
    logic [WIDTH-1:0]  sig_re_q;
    logic [WIDTH-1:0]  sig_im_q;
    logic              m_vld_q;
    logic [WIDTH-1:0]  m_data_q;
    logic [FW-1:0]     m_frame_q;
    logic [BW-1:0]     m_band_q;
    logic              done_q;
    logic              err_timeout_q;
    logic              err_stray_q;

    logic              coe_acc;
    logic              s_acc;
    logic              mel_acc;

    // Ready depends on state only; the last accept moves the state on the same edge, so no extra beat slips in.
    assign coe_rdy_o = (state_q == S_LOAD);
    assign s_rdy_o   = (state_q == S_PRIME) || (state_q == S_HOP);
    assign coe_acc   = coe_vld_i && coe_rdy_o;
    assign s_acc     = s_vld_i && s_rdy_o;
    assign mel_acc   = mel_avail_i && (state_q == S_WAIT_MEL);

    assign busy_o           = (state_q != S_IDLE);
    assign win_coe_lut_en_o = win_en_q;
    assign win_coe_o        = win_coe_q;
    assign start_o          = start_q;
    assign signal_re_o      = sig_re_q;
    assign signal_im_o      = sig_im_q;
    assign m_vld_o          = m_vld_q;
    assign m_data_o         = m_data_q;
    assign m_frame_o        = m_frame_q;
    assign m_band_o         = m_band_q;
    assign done_o           = done_q;
    assign err_timeout_o    = err_timeout_q;
    assign err_stray_o      = err_stray_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            frame_q       <= '0;
            band_q        <= '0;
            wdog_q        <= '0;
            win_en_q      <= 1'b0;
            win_coe_q     <= '0;
            start_q       <= 1'b0;
            sig_re_q      <= '0;
            sig_im_q      <= '0;
            m_vld_q       <= 1'b0;
            m_data_q      <= '0;
            m_frame_q     <= '0;
            m_band_q      <= '0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
        end else begin
            win_en_q <= coe_acc;
            start_q  <= s_acc;
            m_vld_q  <= mel_acc;
            done_q   <= 1'b0;
            if (coe_acc) begin
                win_coe_q <= coe_data_i;
            end
            if (s_acc) begin
                sig_re_q <= s_re_i;
                sig_im_q <= s_im_i;
            end
            if (mel_acc) begin
                m_data_q  <= mel_data_i;
                m_frame_q <= frame_q;
                m_band_q  <= band_q;
            end

            // Abort overrides sequencing but leaves the sticky error flags alone.
            if (abort_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                frame_q <= '0;
                band_q  <= '0;
                wdog_q  <= '0;
            end else begin
                if (mel_avail_i && (state_q != S_WAIT_MEL)) begin
                    err_stray_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (run_i) begin
                            state_q       <= S_LOAD;
                            cnt_q         <= '0;
                            frame_q       <= '0;
                            band_q        <= '0;
                            wdog_q        <= '0;
                            err_timeout_q <= 1'b0;
                            err_stray_q   <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (coe_acc) begin
                            if (cnt_q == WIN_LAST) begin
                                cnt_q   <= '0;
                                state_q <= S_PRIME;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    S_PRIME, S_HOP: begin
                        if (s_acc) begin
                            if (cnt_q == ((state_q == S_PRIME) ? WIN_LAST : HOP_LAST)) begin
                                cnt_q   <= '0;
                                wdog_q  <= '0;
                                state_q <= S_WAIT_MEL;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    S_WAIT_MEL: begin
                        if (mel_avail_i) begin
                            wdog_q <= '0;
                            if (band_q == BAND_LAST) begin
                                band_q <= '0;
                                if (frame_q == FRAME_LAST) begin
                                    frame_q <= '0;
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    frame_q <= frame_q + 1'b1;
                                    state_q <= S_HOP;
                                end
                            end else begin
                                band_q <= band_q + 1'b1;
                            end
                        end else if (wdog_q == WDOG_LAST) begin
                            err_timeout_q <= 1'b1;
                            wdog_q        <= '0;
                            frame_q       <= '0;
                            band_q        <= '0;
                            state_q       <= S_IDLE;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mel_frame_sched.sv
// Randomized scoreboard bench for mel_frame_sched: a stimulus thread queues expected pipeline
// and mel traffic from the scheduling rules, an independent monitor pops and compares it.
module tb_mel_frame_sched;

    localparam int WIDTH     = 16;
    localparam int N_FRAMES  = 3;
    localparam int WIN_LEN   = 8;
    localparam int HOP_LEN   = 4;
    localparam int MEL_BANDS = 2;
    localparam int TIMEOUT   = 16;
    localparam int FW        = $clog2(N_FRAMES);
    localparam int BW        = $clog2(MEL_BANDS);

    logic              clk = 1'b0;
    logic              rstN;
    logic              run;
    logic              abort;
    logic              coeVld;
    logic [WIDTH-1:0]  coeData;
    logic              coeRdy;
    logic              sVld;
    logic [WIDTH-1:0]  sRe;
    logic [WIDTH-1:0]  sIm;
    logic              sRdy;
    logic              winCoeLutEn;
    logic [WIDTH-1:0]  winCoe;
    logic              start;
    logic [WIDTH-1:0]  signalRe;
    logic [WIDTH-1:0]  signalIm;
    logic              melAvail;
    logic [WIDTH-1:0]  melData;
    logic              mVld;
    logic [WIDTH-1:0]  mData;
    logic [FW-1:0]     mFrame;
    logic [BW-1:0]     mBand;
    logic              busy;
    logic              done;
    logic              errTimeout;
    logic              errStray;

    int          checks      = 0;
    int          failures    = 0;
    int          cyc         = 0;
    int          expDoneCyc  = -1;
    int          totalStarts = 0;
    int          totalCoe    = 0;
    bit          gapMode     = 1'b0;
    logic [31:0] expCoe[$];
    logic [31:0] expSample[$];
    logic [31:0] expMel[$];
    logic [31:0] monExp;

    mel_frame_sched #(
        .WIDTH(WIDTH), .N_FRAMES(N_FRAMES), .WIN_LEN(WIN_LEN),
        .HOP_LEN(HOP_LEN), .MEL_BANDS(MEL_BANDS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_n_i(rstN), .run_i(run), .abort_i(abort),
        .coe_vld_i(coeVld), .coe_data_i(coeData), .coe_rdy_o(coeRdy),
        .s_vld_i(sVld), .s_re_i(sRe), .s_im_i(sIm), .s_rdy_o(sRdy),
        .win_coe_lut_en_o(winCoeLutEn), .win_coe_o(winCoe),
        .start_o(start), .signal_re_o(signalRe), .signal_im_o(signalIm),
        .mel_avail_i(melAvail), .mel_data_i(melData),
        .m_vld_o(mVld), .m_data_o(mData), .m_frame_o(mFrame), .m_band_o(mBand),
        .busy_o(busy), .done_o(done), .err_timeout_o(errTimeout), .err_stray_o(errStray)
    );

    // Free-running clock plus a cycle index used to place the expected done pulse.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got a pulse, required none (scoreboard empty)", name);
    endtask

    // Monitor: every forwarded beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (winCoeLutEn === 1'b1) begin
            totalCoe++;
            if (expCoe.size() == 0) begin
                reportUnexpected("win_coe_lut_en");
            end else begin
                monExp = expCoe.pop_front();
                checkOutput("win_coe", 32'(winCoe), monExp);
            end
        end
        if (start === 1'b1) begin
            totalStarts++;
            if (expSample.size() == 0) begin
                reportUnexpected("start");
            end else begin
                monExp = expSample.pop_front();
                checkOutput("signal_re_im", {signalRe, signalIm}, monExp);
            end
        end
        if (mVld === 1'b1) begin
            if (expMel.size() == 0) begin
                reportUnexpected("m_vld");
            end else begin
                monExp = expMel.pop_front();
                checkOutput("m_data", 32'(mData), 32'(monExp[31:16]));
                checkOutput("m_frame", 32'(mFrame), 32'(monExp[15:8]));
                checkOutput("m_band", 32'(mBand), 32'(monExp[7:0]));
            end
        end
        checkOutput("done_timing", 32'(done), 32'(cyc == expDoneCyc));
    end

    // Offers one coefficient or sample beat, holding it until accepted; returns on the following negedge.
    task automatic applyStimulus(input bit isCoe, input logic [31:0] payload);
        int guard;
        bit v;
        guard = 0;
        if (isCoe) coeData = payload[15:0];
        else begin
            sRe = payload[31:16];
            sIm = payload[15:0];
        end
        forever begin
            v = gapMode ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (isCoe) coeVld = v;
            else       sVld   = v;
            if (v && (isCoe ? coeRdy : sRdy)) begin
                if (isCoe) expCoe.push_back(payload);
                else       expSample.push_back(payload);
                @(negedge clk);
                coeVld = 1'b0;
                sVld   = 1'b0;
                return;
            end
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL handshake_wait: got no ready in %0d cycles, required ready", guard);
                coeVld = 1'b0;
                sVld   = 1'b0;
                return;
            end
        end
    endtask

    task automatic loadCoefs(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, {16'h0, 16'($urandom)});
    endtask

    task automatic sendSamples(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, {16'($urandom), 16'($urandom)});
    endtask

    task automatic pulseRun();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Returns the mel bands of one frame while a bait sample sits on the input, which must never be taken.
    task automatic melPhase(input int frame, input bit lastFrame, input int expTotal);
        logic [15:0] md;
        sVld = 1'b1;
        sRe  = 16'($urandom);
        sIm  = 16'($urandom);
        @(negedge clk);
        checkOutput("s_rdy_wait_mel", 32'(sRdy), 32'd0);
        checkOutput("start_count", 32'(totalStarts), 32'(expTotal));
        for (int b = 0; b < MEL_BANDS; b++) begin
            repeat ($urandom_range(3, 0)) begin
                @(negedge clk);
                checkOutput("s_rdy_wait_mel", 32'(sRdy), 32'd0);
            end
            md       = 16'($urandom);
            melAvail = 1'b1;
            melData  = md;
            expMel.push_back({md, 8'(frame), 8'(b)});
            if (b == MEL_BANDS - 1) begin
                sVld = 1'b0;
                if (lastFrame) expDoneCyc = cyc + 1;
            end
            @(negedge clk);
            melAvail = 1'b0;
        end
    endtask

    task automatic strayPulse();
        melAvail = 1'b1;
        melData  = 16'($urandom);
        @(negedge clk);
        melAvail = 1'b0;
        checkOutput("err_stray_set", 32'(errStray), 32'd1);
        checkOutput("m_vld_on_stray", 32'(mVld), 32'd0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_win_coe_lut_en", 32'(winCoeLutEn), 32'd0);
        checkOutput("rst_win_coe", 32'(winCoe), 32'd0);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_signal_re", 32'(signalRe), 32'd0);
        checkOutput("rst_signal_im", 32'(signalIm), 32'd0);
        checkOutput("rst_m_vld", 32'(mVld), 32'd0);
        checkOutput("rst_m_data", 32'(mData), 32'd0);
        checkOutput("rst_m_frame", 32'(mFrame), 32'd0);
        checkOutput("rst_m_band", 32'(mBand), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err_timeout", 32'(errTimeout), 32'd0);
        checkOutput("rst_err_stray", 32'(errStray), 32'd0);
        checkOutput("rst_coe_rdy", 32'(coeRdy), 32'd0);
        checkOutput("rst_s_rdy", 32'(sRdy), 32'd0);
    endtask

    task automatic fullRun(input int strayAfter);
        int base;
        int coeBase;
        pulseRun();
        checkOutput("busy_after_run", 32'(busy), 32'd1);
        checkOutput("err_timeout_after_run", 32'(errTimeout), 32'd0);
        checkOutput("err_stray_after_run", 32'(errStray), 32'd0);
        base    = totalStarts;
        coeBase = totalCoe;
        loadCoefs(WIN_LEN);
        for (int f = 0; f < N_FRAMES; f++) begin
            if (f == 0 && strayAfter >= 0) begin
                sendSamples(strayAfter);
                strayPulse();
                sendSamples(WIN_LEN - strayAfter);
            end else begin
                sendSamples((f == 0) ? WIN_LEN : HOP_LEN);
            end
            melPhase(f, f == N_FRAMES - 1, base + WIN_LEN + f * HOP_LEN);
        end
        @(negedge clk);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("coe_count", 32'(totalCoe - coeBase), 32'(WIN_LEN));
        checkOutput("queues_drained", 32'(expCoe.size() + expSample.size() + expMel.size()), 32'd0);
        checkOutput("err_timeout_in_run", 32'(errTimeout), 32'd0);
        if (strayAfter >= 0) checkOutput("err_stray_sticky", 32'(errStray), 32'd1);
        expDoneCyc = -1;
    endtask

    task automatic timeoutTest();
        pulseRun();
        loadCoefs(WIN_LEN);
        sendSamples(WIN_LEN);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("busy_before_timeout", 32'(busy), 32'd1);
        checkOutput("err_timeout_early", 32'(errTimeout), 32'd0);
        @(negedge clk);
        checkOutput("busy_after_timeout", 32'(busy), 32'd0);
        checkOutput("err_timeout_set", 32'(errTimeout), 32'd1);
        checkOutput("queues_timeout", 32'(expCoe.size() + expSample.size() + expMel.size()), 32'd0);
    endtask

    task automatic abortTest();
        int base;
        logic [31:0] pay;
        pulseRun();
        base = totalStarts;
        loadCoefs(WIN_LEN);
        sendSamples(WIN_LEN);
        melPhase(0, 1'b0, base + WIN_LEN);
        sendSamples(2);
        pay = {16'($urandom), 16'($urandom)};
        checkOutput("s_rdy_in_hop", 32'(sRdy), 32'd1);
        abort = 1'b1;
        sVld  = 1'b1;
        sRe   = pay[31:16];
        sIm   = pay[15:0];
        expSample.push_back(pay);
        @(negedge clk);
        abort = 1'b0;
        sVld  = 1'b0;
        checkOutput("busy_after_abort", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("queues_abort", 32'(expCoe.size() + expSample.size() + expMel.size()), 32'd0);
        fullRun(-1);
    endtask

    task automatic resetTest();
        pulseRun();
        loadCoefs(WIN_LEN / 2);
        strayPulse();
        rstN = 1'b0;
        run  = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        run  = 1'b0;
        checkResetOutputs();
        @(negedge clk);
        checkOutput("busy_run_in_reset", 32'(busy), 32'd0);
        checkOutput("coe_rdy_run_in_reset", 32'(coeRdy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got still running at %0t, required finish", $time);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rstN = 1'b0; run = 1'b0; abort = 1'b0;
        coeVld = 1'b0; coeData = '0;
        sVld = 1'b0; sRe = '0; sIm = '0;
        melAvail = 1'b0; melData = '0;
        repeat (2) @(negedge clk);
        checkResetOutputs();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] continuous run");
        gapMode = 1'b0;
        fullRun(-1);
        $display("[TB] gapped runs");
        gapMode = 1'b1;
        fullRun(-1);
        fullRun(-1);
        $display("[TB] watchdog timeout");
        timeoutTest();
        $display("[TB] stray mel pulse in prime");
        gapMode = 1'b0;
        fullRun(3);
        $display("[TB] abort in hop");
        gapMode = 1'b1;
        abortTest();
        $display("[TB] reset mid-run");
        resetTest();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
